mask_compress_expand_stream: RTL and testbench

MASK_COMPRESS_EXPAND_STREAM -- requirements
Module: mask_compress_expand_stream

---
 rtl/mask_compress_expand_stream.sv | 215 +++++++++++++++++++++
 tb/tb_mask_compress_expand_stream.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mask_compress_expand_stream.sv
// mask_compress_expand_stream
//
// Two-stage streaming mask compress / expand unit.
//   compress (mode=0): the elements of datain_a selected by maskin are packed
//     into the low output lanes in ascending order; the remaining upper lanes
//     carry datain_src.
//   expand   (mode=1): the low elements of datain_a are scattered, in order,
//     into the lanes whose mask bit is set; clear lanes carry datain_src.
//
// Stage 1 registers the input vectors together with a per-lane source index
// and a lane-active flag. Stage 2 performs the lane muxing and registers
// dataout / ocount. Each stage advances when the stage after it is empty or
// is itself advancing, so a full pipeline keeps one vector per cycle moving.
//
// Build option:
//   MASK_COMPRESS_EXPAND_EN  defined   -> mode selects compress or expand.
//                            undefined -> mode is ignored, compress only,
//                                         expand lane mapping not built.
//
// Ports:
//   clock       in   rising-edge clock
//   resetn      in   asynchronous active-low reset
//   ivalid      in   upstream vector valid
//   oready      out  a vector can be accepted this cycle
//   ovalid      out  dataout / ocount valid
//   iready      in   downstream accepts the output this cycle
//   mode        in   0 = compress, 1 = expand (sampled with ivalid)
//   maskin      in   element select, bit i for element i
//   datain_src  in   pass-through elements, element i at [i*DW +: DW]
//   datain_a    in   source elements, same packing
//   dataout     out  result vector, same packing
//   ocount      out  popcount of the mask belonging to the output vector

module mask_compress_expand_stream #(
  parameter int VECTOR_SIZE = 8,
  parameter int DATA_WIDTH  = 64
) (
  input  logic                                clock,
  input  logic                                resetn,
  input  logic                                ivalid,
  output logic                                oready,
  output logic                                ovalid,
  input  logic                                iready,
  input  logic                                mode,
  input  logic [VECTOR_SIZE-1:0]              maskin,
  input  logic [VECTOR_SIZE*DATA_WIDTH-1:0]   datain_src,
  input  logic [VECTOR_SIZE*DATA_WIDTH-1:0]   datain_a,
  output logic [VECTOR_SIZE*DATA_WIDTH-1:0]   dataout,
  output logic [$clog2(VECTOR_SIZE+1)-1:0]    ocount
);

  localparam int VS = VECTOR_SIZE;
  localparam int DW = DATA_WIDTH;
  localparam int IW = $clog2(VS);
  localparam int CW = $clog2(VS + 1);
  localparam int VW = VS * DW;

  // ------------------------------------------------------------------
  // Mask ranks: rank[i] = number of set mask bits strictly below bit i.
  // ------------------------------------------------------------------
  logic [CW-1:0] rank [VS];
  logic [CW-1:0] pop_count;

  always_comb begin
    logic [CW-1:0] acc;
    acc = '0;
    for (int i = 0; i < VS; i++) begin
      rank[i] = acc;
      acc     = acc + CW'(maskin[i]);
    end
    pop_count = acc;
  end

  // ------------------------------------------------------------------
  // Compress mapping: output lane j takes the element whose mask bit is
  // set and whose rank equals j. At most one bit can match per lane.
  // ------------------------------------------------------------------
  logic [VS*IW-1:0] cmp_sel;
  logic [VS-1:0]    cmp_act;

  genvar gi;
  generate
    for (gi = 0; gi < VS; gi++) begin : g_cmp
      logic [IW-1:0] sel;
      logic          act;

      always_comb begin
        sel = '0;
        act = 1'b0;
        for (int i = 0; i < VS; i++) begin
          if (maskin[i] && (rank[i] == CW'(gi))) begin
            sel = IW'(i);
            act = 1'b1;
          end
        end
      end

      assign cmp_sel[gi*IW +: IW] = sel;
      assign cmp_act[gi]          = act;
    end
  endgenerate

  // ------------------------------------------------------------------
  // Lane mapping chosen for this vector.
  // ------------------------------------------------------------------
  logic [VS*IW-1:0] lane_sel;
  logic [VS-1:0]    lane_act;

`ifdef MASK_COMPRESS_EXPAND_EN
  // Expand mapping: a set lane i takes element rank[i]; rank[i] < VS for
  // every lane, so the low IW bits hold it exactly.
  logic [VS*IW-1:0] exp_sel;

  generate
    for (gi = 0; gi < VS; gi++) begin : g_exp
      assign exp_sel[gi*IW +: IW] = rank[gi][IW-1:0];
    end
  endgenerate

  assign lane_sel = mode ? exp_sel : cmp_sel;
  assign lane_act = mode ? maskin  : cmp_act;
`else
  logic unused_mode;

  assign unused_mode = mode;
  assign lane_sel    = cmp_sel;
  assign lane_act    = cmp_act;
`endif

  // ------------------------------------------------------------------
  // Handshake: a stage advances when its successor is empty or advancing.
  // ------------------------------------------------------------------
  logic s1_valid_reg;
  logic ovalid_reg;
  logic s1_adv;
  logic s2_adv;
  logic in_fire;

  assign s2_adv  = !ovalid_reg || iready;
  assign s1_adv  = !s1_valid_reg || s2_adv;
  assign oready  = s1_adv;
  assign in_fire = ivalid && s1_adv;

  // ------------------------------------------------------------------
  // Stage 1: input vectors plus lane mapping.
  // ------------------------------------------------------------------
  logic [VW-1:0]    s1_src_reg;
  logic [VW-1:0]    s1_a_reg;
  logic [VS*IW-1:0] s1_sel_reg;
  logic [VS-1:0]    s1_act_reg;
  logic [CW-1:0]    s1_cnt_reg;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_valid_reg <= 1'b0;
      s1_src_reg   <= '0;
      s1_a_reg     <= '0;
      s1_sel_reg   <= '0;
      s1_act_reg   <= '0;
      s1_cnt_reg   <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid_reg <= ivalid;
      end
      // Payload only moves on a real transfer so idle inputs leave no trace.
      if (in_fire) begin
        s1_src_reg <= datain_src;
        s1_a_reg   <= datain_a;
        s1_sel_reg <= lane_sel;
        s1_act_reg <= lane_act;
        s1_cnt_reg <= pop_count;
      end
    end
  end

  // ------------------------------------------------------------------
  // Stage 2: lane muxing and output registers.
  // ------------------------------------------------------------------
  logic [VW-1:0] dataout_next;
  logic [VW-1:0] dataout_reg;
  logic [CW-1:0] ocount_reg;

  generate
    for (gi = 0; gi < VS; gi++) begin : g_out
      logic [IW-1:0] sel;

      assign sel = s1_sel_reg[gi*IW +: IW];
      assign dataout_next[gi*DW +: DW] = s1_act_reg[gi] ? s1_a_reg[int'(sel)*DW +: DW]
                                                        : s1_src_reg[gi*DW +: DW];
    end
  endgenerate

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ovalid_reg  <= 1'b0;
      dataout_reg <= '0;
      ocount_reg  <= '0;
    end else begin
      if (s2_adv) begin
        ovalid_reg <= s1_valid_reg;
      end
      // Output registers only change when a new vector moves in, which keeps
      // them stable while the downstream stalls.
      if (s2_adv && s1_valid_reg) begin
        dataout_reg <= dataout_next;
        ocount_reg  <= s1_cnt_reg;
      end
    end
  end

  assign ovalid  = ovalid_reg;
  assign dataout = dataout_reg;
  assign ocount  = ocount_reg;

endmodule

// File: tb/tb_mask_compress_expand_stream.sv
// Testbench for mask_compress_expand_stream (VECTOR_SIZE=8, DATA_WIDTH=64).
// Directed table of vectors, hand-written sequences for back-to-back, stall
// and mid-stream reset behaviour, and randomized streams scored against a
// queue-based reference model.

module tb_mask_compress_expand_stream;

  localparam int VS = 8;
  localparam int DW = 64;
  localparam int VW = VS * DW;
  localparam int CW = $clog2(VS + 1);

  typedef logic [VW-1:0] vec_t;

  typedef struct {
    vec_t data;
    int   cnt;
  } exp_t;

  typedef struct {
    logic          mode;
    logic [VS-1:0] mask;
    vec_t          a;
    vec_t          src;
    vec_t          exp_data;
    int            exp_cnt;
  } vec_rec_t;

  logic          clock;
  logic          resetn;
  logic          ivalid;
  logic          oready;
  logic          ovalid;
  logic          iready;
  logic          mode;
  logic [VS-1:0] maskin;
  vec_t          datain_src;
  vec_t          datain_a;
  vec_t          dataout;
  logic [CW-1:0] ocount;

  int checks   = 0;
  int failures = 0;

  mask_compress_expand_stream #(
    .VECTOR_SIZE (VS),
    .DATA_WIDTH  (DW)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .ivalid     (ivalid),
    .oready     (oready),
    .ovalid     (ovalid),
    .iready     (iready),
    .mode       (mode),
    .maskin     (maskin),
    .datain_src (datain_src),
    .datain_a   (datain_a),
    .dataout    (dataout),
    .ocount     (ocount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input vec_t act, input vec_t req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic vec_t pk(input logic [63:0] bytes);
    vec_t v;
    v = '0;
    for (int i = 0; i < VS; i++) v[i*DW +: 8] = bytes[i*8 +: 8];
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference: collect the selected elements of a in order, then place them.
  function automatic exp_t ref_model(input logic m, input logic [VS-1:0] mk,
                                     input vec_t a, input vec_t s);
    logic [DW-1:0] q[$];
    exp_t r;
    bit   do_expand;
    int   k;
`ifdef MASK_COMPRESS_EXPAND_EN
    do_expand = m;
`else
    do_expand = 1'b0;
`endif
    r.data = s;
    r.cnt  = 0;
    for (int i = 0; i < VS; i++) begin
      if (mk[i]) begin
        q.push_back(a[i*DW +: DW]);
        r.cnt++;
      end
    end
    if (!do_expand) begin
      for (int j = 0; j < q.size(); j++) r.data[j*DW +: DW] = q[j];
    end else begin
      k = 0;
      for (int i = 0; i < VS; i++) begin
        if (mk[i]) begin
          r.data[i*DW +: DW] = q[k];
          k++;
        end
      end
    end
    return r;
  endfunction

  task automatic drive_idle();
    ivalid     = 1'b0;
    mode       = 1'($urandom);
    maskin     = VS'($urandom);
    datain_a   = rand_vec();
    datain_src = rand_vec();
  endtask

  task automatic offer(input logic m, input logic [VS-1:0] mk, input vec_t a, input vec_t s);
    ivalid     = 1'b1;
    mode       = m;
    maskin     = mk;
    datain_a   = a;
    datain_src = s;
  endtask

  function automatic logic [VS-1:0] rand_mask();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      default: return VS'($urandom);
    endcase
  endfunction

  // Stream test. pat 0: random ivalid/iready; pat 1: continuous offers,
  // iready low on cycles 3..6.
  task automatic run_stream(input int nvec, input int pat, input int maxcyc, input string tag);
    exp_t          expq[$];
    exp_t          e;
    int            sent;
    int            got;
    int            cyc;
    int            full_stalls;
    bit            prev_hold;
    vec_t          prev_data;
    logic [CW-1:0] prev_cnt;
    bit            have;
    logic          cm;
    logic [VS-1:0] cmk;
    vec_t          ca;
    vec_t          cs;
    sent = 0; got = 0; cyc = 0; full_stalls = 0;
    prev_hold = 1'b0; prev_data = '0; prev_cnt = '0; have = 1'b0;
    cm = 1'b0; cmk = '0; ca = '0; cs = '0;
    while ((got < nvec) && (cyc < maxcyc)) begin
      @(posedge clock); #1;
      if (pat == 1) iready = !((cyc >= 3) && (cyc <= 6));
      else          iready = ($urandom_range(0, 2) != 0);
      if (sent < nvec) begin
        if (!have) begin
          cm = 1'($urandom); cmk = rand_mask(); ca = rand_vec(); cs = rand_vec();
          have = 1'b1;
        end
        if ((pat == 1) || ($urandom_range(0, 3) != 0)) offer(cm, cmk, ca, cs);
        else drive_idle();
      end else begin
        drive_idle();
      end
      @(negedge clock);
      if (prev_hold) begin
        chk($sformatf("%s_hold_valid c%0d", tag, cyc), vec_t'(ovalid), vec_t'(1'b1));
        chk($sformatf("%s_hold_data c%0d", tag, cyc), dataout, prev_data);
        chk($sformatf("%s_hold_cnt c%0d", tag, cyc), vec_t'(ocount), vec_t'(prev_cnt));
      end
      chk($sformatf("%s_oready c%0d", tag, cyc), vec_t'(oready),
          vec_t'(!((expq.size() == 2) && !iready)));
      if (expq.size() == 0)
        chk($sformatf("%s_idle_ovalid c%0d", tag, cyc), vec_t'(ovalid), vec_t'(1'b0));
      if (ovalid && iready && (expq.size() != 0)) begin
        e = expq.pop_front();
        chk($sformatf("%s_data v%0d", tag, got), dataout, e.data);
        chk($sformatf("%s_cnt v%0d", tag, got), vec_t'(ocount), vec_t'(e.cnt));
        got++;
      end
      prev_hold = ovalid && !iready;
      prev_data = dataout;
      prev_cnt  = ocount;
      if ((expq.size() == 2) && !iready) full_stalls++;
      if (ivalid && oready) begin
        expq.push_back(ref_model(cm, cmk, ca, cs));
        sent++;
        have = 1'b0;
      end
      cyc++;
    end
    chk($sformatf("%s_delivered", tag), vec_t'(got), vec_t'(nvec));
    if (pat == 1)
      chk($sformatf("%s_full_stall_seen", tag), vec_t'(full_stalls > 0), vec_t'(1'b1));
  endtask

  localparam logic [63:0] A_B   = 64'h17161514_13121110;
  localparam logic [63:0] S_B   = 64'hF7F6F5F4_F3F2F1F0;
  localparam logic [63:0] C66   = 64'hF7F6F5F4_16151211;
  localparam logic [63:0] C01   = 64'hF7F6F5F4_F3F2F110;
  localparam logic [63:0] C80   = 64'hF7F6F5F4_F3F2F117;
  localparam logic [63:0] CA5   = 64'hF7F6F5F4_17151210;
`ifdef MASK_COMPRESS_EXPAND_EN
  localparam logic [63:0] E66   = 64'hF71312F4_F31110F0;
  localparam logic [63:0] E80   = 64'h10F6F5F4_F3F2F1F0;
  localparam logic [63:0] EA5   = 64'h13F612F4_F311F110;
`else
  localparam logic [63:0] E66   = C66;
  localparam logic [63:0] E80   = C80;
  localparam logic [63:0] EA5   = CA5;
`endif
  localparam int NT = 11;

  initial begin
    vec_rec_t tbl[NT];
    vec_t     av;
    vec_t     sv;
    exp_t     e;
    logic [VS-1:0] mk;
    vec_t     a2;
    vec_t     s2;

    av = pk(A_B);
    sv = pk(S_B);
    tbl[0]  = '{mode: 1'b0, mask: 8'h66, a: av, src: sv, exp_data: pk(C66), exp_cnt: 4};
    tbl[1]  = '{mode: 1'b1, mask: 8'h66, a: av, src: sv, exp_data: pk(E66), exp_cnt: 4};
    tbl[2]  = '{mode: 1'b0, mask: 8'h00, a: av, src: sv, exp_data: sv,      exp_cnt: 0};
    tbl[3]  = '{mode: 1'b1, mask: 8'h00, a: av, src: sv, exp_data: sv,      exp_cnt: 0};
    tbl[4]  = '{mode: 1'b0, mask: 8'hFF, a: av, src: sv, exp_data: av,      exp_cnt: 8};
    tbl[5]  = '{mode: 1'b1, mask: 8'hFF, a: av, src: sv, exp_data: av,      exp_cnt: 8};
    tbl[6]  = '{mode: 1'b0, mask: 8'h01, a: av, src: sv, exp_data: pk(C01), exp_cnt: 1};
    tbl[7]  = '{mode: 1'b0, mask: 8'h80, a: av, src: sv, exp_data: pk(C80), exp_cnt: 1};
    tbl[8]  = '{mode: 1'b1, mask: 8'h80, a: av, src: sv, exp_data: pk(E80), exp_cnt: 1};
    tbl[9]  = '{mode: 1'b0, mask: 8'hA5, a: av, src: sv, exp_data: pk(CA5), exp_cnt: 4};
    tbl[10] = '{mode: 1'b1, mask: 8'hA5, a: av, src: sv, exp_data: pk(EA5), exp_cnt: 4};

    // Reset state.
    resetn = 1'b0;
    iready = 1'b0;
    drive_idle();
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_ovalid", vec_t'(ovalid), vec_t'(1'b0));
    chk("rst_dataout", dataout, '0);
    chk("rst_ocount", vec_t'(ocount), '0);
    chk("rst_oready", vec_t'(oready), vec_t'(1'b1));
    resetn = 1'b1;

    // Directed table: one vector at a time, exact 2-cycle latency.
    for (int t = 0; t < NT; t++) begin
      @(posedge clock); #1;
      iready = 1'b1;
      offer(tbl[t].mode, tbl[t].mask, tbl[t].a, tbl[t].src);
      @(negedge clock);
      chk($sformatf("tbl%0d_oready", t), vec_t'(oready), vec_t'(1'b1));
      @(posedge clock); #1;
      drive_idle();
      @(negedge clock);
      chk($sformatf("tbl%0d_early_ovalid", t), vec_t'(ovalid), vec_t'(1'b0));
      @(posedge clock); #1;
      @(negedge clock);
      chk($sformatf("tbl%0d_ovalid", t), vec_t'(ovalid), vec_t'(1'b1));
      chk($sformatf("tbl%0d_data", t), dataout, tbl[t].exp_data);
      chk($sformatf("tbl%0d_cnt", t), vec_t'(ocount), vec_t'(tbl[t].exp_cnt));
    end

    // Back-to-back all-zero then all-ones masks.
    @(posedge clock); #1;
    iready = 1'b1;
    offer(1'b0, 8'h00, av, sv);
    @(posedge clock); #1;
    offer(1'b1, 8'hFF, av, sv);
    @(posedge clock); #1;
    drive_idle();
    @(negedge clock);
    chk("b2b0_ovalid", vec_t'(ovalid), vec_t'(1'b1));
    chk("b2b0_data", dataout, sv);
    chk("b2b0_cnt", vec_t'(ocount), vec_t'(0));
    @(posedge clock); #1;
    @(negedge clock);
    chk("b2b1_ovalid", vec_t'(ovalid), vec_t'(1'b1));
    chk("b2b1_data", dataout, av);
    chk("b2b1_cnt", vec_t'(ocount), vec_t'(8));
    @(posedge clock); #1;
    @(negedge clock);
    chk("b2b_drained", vec_t'(ovalid), vec_t'(1'b0));

    // Five vectors with a downstream stall on cycles 3..6.
    run_stream(5, 1, 60, "stall");

    // Mid-stream reset with two vectors in flight.
    @(posedge clock); #1;
    iready = 1'b1;
    offer(1'b0, 8'h0F, rand_vec(), rand_vec());
    @(posedge clock); #1;
    offer(1'b1, 8'hF0, rand_vec(), rand_vec());
    @(posedge clock); #1;
    drive_idle();
    iready = 1'b0;
    @(negedge clock);
    chk("mrst_pre_ovalid", vec_t'(ovalid), vec_t'(1'b1));
    #1 resetn = 1'b0;
    #1;
    chk("mrst_ovalid", vec_t'(ovalid), vec_t'(1'b0));
    chk("mrst_oready", vec_t'(oready), vec_t'(1'b1));
    chk("mrst_dataout", dataout, '0);
    chk("mrst_ocount", vec_t'(ocount), '0);
    @(posedge clock); #1;
    @(negedge clock);
    resetn = 1'b1;
    iready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clock); #1;
      drive_idle();
      @(negedge clock);
      chk($sformatf("mrst_gone c%0d", c), vec_t'(ovalid), vec_t'(1'b0));
    end
    mk = rand_mask(); a2 = rand_vec(); s2 = rand_vec();
    e  = ref_model(1'b0, mk, a2, s2);
    @(posedge clock); #1;
    offer(1'b0, mk, a2, s2);
    @(posedge clock); #1;
    drive_idle();
    @(negedge clock);
    chk("mrst_next_early", vec_t'(ovalid), vec_t'(1'b0));
    @(posedge clock); #1;
    @(negedge clock);
    chk("mrst_next_ovalid", vec_t'(ovalid), vec_t'(1'b1));
    chk("mrst_next_data", dataout, e.data);
    chk("mrst_next_cnt", vec_t'(ocount), vec_t'(e.cnt));
    @(posedge clock); #1;
    drive_idle();

    // Randomized streams against the reference model.
    run_stream(200, 0, 4000, "rand");
    run_stream(100, 0, 2000, "rand2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
